// File: rtl/compress1.sv
// Kyber Compress_q(x,1): 256 coefficients in (two per beat) -> 32 packed bytes out, one per readout.
// Define COMPRESS1_RANGE_CHECK_EN to add a sticky range_err flag for coefficients >= Q.
module compress1 #(
  parameter int Q       = 3329,
  parameter int N_BYTES = 32,
  parameter int IW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          readin,
  input  logic          full_in,
  input  logic [15:0]   comp_din_1,
  input  logic [15:0]   comp_din_2,
  input  logic [IW-1:0] in_index,
  input  logic          readout,
  output logic [7:0]    comp_dout,
  output logic [IW-1:0] out_index,
  output logic          readin_ok,
  output logic          readout_ok,
  output logic          range_err
);

  localparam int NBITS   = N_BYTES * 8;
  localparam int BW      = $clog2(NBITS);
  localparam int N_BEATS = N_BYTES * 4;
  localparam logic [15:0]   LO        = 16'((Q + 3) / 4);
  localparam logic [15:0]   HI        = 16'((3 * Q) / 4);
  localparam logic [IW:0]   BEATS_LIM = (IW+1)'(N_BEATS);
  localparam logic [IW-1:0] LAST_BYTE = IW'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, INPUT, DRAIN} state_t;

  state_t           state_q;
  logic [NBITS-1:0] buf_q, buf_d;
  logic [IW-1:0]    j_q;
  logic             readin_ok_q, readout_ok_q;

  logic          accept, idx_ok, c1, c2;
  logic [BW-1:0] bit_pos, byte_pos;

  assign accept   = set & readin & (state_q == INPUT);
  assign idx_ok   = {1'b0, in_index} < BEATS_LIM;
  assign c1       = (comp_din_1 >= LO) && (comp_din_1 <= HI);
  assign c2       = (comp_din_2 >= LO) && (comp_din_2 <= HI);
  assign bit_pos  = BW'({in_index, 1'b0});
  assign byte_pos = BW'({j_q, 3'b000});

  // IDLE lasts exactly one cycle and wipes the buffer, so unwritten bits read as 0.
  always_comb begin
    buf_d = buf_q;
    if (state_q == IDLE) begin
      buf_d = '0;
    end else if (accept && idx_ok) begin
      buf_d[bit_pos]         = c1;
      buf_d[bit_pos + 1'b1]  = c2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      j_q          <= '0;
      readin_ok_q  <= 1'b0;
      readout_ok_q <= 1'b0;
    end else if (set) begin
      buf_q <= buf_d;
      case (state_q)
        IDLE: begin
          state_q     <= INPUT;
          readin_ok_q <= 1'b1;
        end
        INPUT: begin
          if (full_in) begin
            state_q      <= DRAIN;
            readin_ok_q  <= 1'b0;
            readout_ok_q <= 1'b1;
            j_q          <= '0;
          end
        end
        DRAIN: begin
          if (readout) begin
            if (j_q == LAST_BYTE) begin
              state_q      <= IDLE;
              readout_ok_q <= 1'b0;
              j_q          <= '0;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COMPRESS1_RANGE_CHECK_EN
  localparam logic [15:0] QW = 16'(Q);
  logic range_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      range_err_q <= 1'b0;
    end else if (accept && ((comp_din_1 >= QW) || (comp_din_2 >= QW))) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  assign comp_dout  = readout_ok_q ? buf_q[byte_pos +: 8] : 8'h00;
  assign out_index  = j_q;
  assign readin_ok  = readin_ok_q;
  assign readout_ok = readout_ok_q;

endmodule

// File: tb/tb_compress1.sv
// Directed bench for compress1: hand-computed packed bytes, stalls, clock-enable freeze, reset abort.
module tb_compress1;

  logic        clk = 1'b0;
  logic        reset, set, readin, full_in, readout;
  logic [15:0] comp_din_1, comp_din_2;
  logic [7:0]  in_index;
  logic [7:0]  comp_dout;
  logic [7:0]  out_index;
  logic        readin_ok, readout_ok, range_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_b [32];

`ifdef COMPRESS1_RANGE_CHECK_EN
  localparam logic RC_EXP = 1'b1;
`else
  localparam logic RC_EXP = 1'b0;
`endif

  compress1 dut (
    .clk(clk), .reset(reset), .set(set), .readin(readin), .full_in(full_in),
    .comp_din_1(comp_din_1), .comp_din_2(comp_din_2), .in_index(in_index),
    .readout(readout), .comp_dout(comp_dout), .out_index(out_index),
    .readin_ok(readin_ok), .readout_ok(readout_ok), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int k, input int a, input int b, input bit last);
    readin     = 1'b1;
    in_index   = 8'(k);
    comp_din_1 = 16'(a);
    comp_din_2 = 16'(b);
    full_in    = last;
    tick();
    readin     = 1'b0;
    full_in    = 1'b0;
  endtask

  task automatic fill_exp(input logic [7:0] v);
    for (int i = 0; i < 32; i++) exp_b[i] = v;
  endtask

  // Drains one frame against exp_b; with stall=1 each byte is held one cycle first.
  task automatic drain(input bit stall);
    for (int j = 0; j < 32; j++) begin
      chk("readout_ok", 32'(readout_ok), 32'd1);
      chk("dout", 32'(comp_dout), 32'(exp_b[j]));
      chk("out_index", 32'(out_index), 32'(j));
      if (stall) begin
        readout = 1'b0;
        tick();
        chk("held_dout", 32'(comp_dout), 32'(exp_b[j]));
        chk("held_index", 32'(out_index), 32'(j));
      end
      readout = 1'b1;
      tick();
    end
    readout = 1'b0;
    chk("done_readout_ok", 32'(readout_ok), 32'd0);
    chk("done_dout", 32'(comp_dout), 32'd0);
    tick();
    chk("rearm_readin_ok", 32'(readin_ok), 32'd1);
  endtask

  initial begin
    reset = 1'b0; set = 1'b1; readin = 1'b0; full_in = 1'b0; readout = 1'b0;
    comp_din_1 = '0; comp_din_2 = '0; in_index = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(comp_dout), 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_readin_ok", 32'(readin_ok), 32'd0);
    chk("rst_readout_ok", 32'(readout_ok), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);

    reset = 1'b1;
    tick();
    chk("idle_to_input", 32'(readin_ok), 32'd1);
    chk("input_readout_ok", 32'(readout_ok), 32'd0);

    // Frame A: all zero coefficients, full_in with the last beat
    for (int k = 0; k < 128; k++) beat(k, 0, 0, k == 127);
    chk("full_readin_ok", 32'(readin_ok), 32'd0);
    chk("full_readout_ok", 32'(readout_ok), 32'd1);
    fill_exp(8'h00);
    drain(1'b0);

    // Frame B: 1665 everywhere
    for (int k = 0; k < 128; k++) beat(k, 1665, 1665, k == 127);
    fill_exp(8'hFF);
    drain(1'b0);

    // Frame C: threshold edges, overwrite, out-of-range index, frozen clock enable
    beat(5, 1665, 1665, 1'b0);
    beat(0, 832, 833, 1'b0);
    beat(1, 2496, 2497, 1'b0);
    beat(5, 0, 0, 1'b0);
    beat(200, 1665, 1665, 1'b0);
    set = 1'b0;
    beat(2, 1665, 1665, 1'b1);
    chk("freeze_readin_ok", 32'(readin_ok), 32'd1);
    chk("freeze_readout_ok", 32'(readout_ok), 32'd0);
    set = 1'b1;
    full_in = 1'b1;
    tick();
    full_in = 1'b0;
    fill_exp(8'h00);
    exp_b[0] = 8'h06;
    drain(1'b0);

    // Frame D: full_in with no beats, stalled drain, set=0 holds the index
    full_in = 1'b1;
    tick();
    full_in = 1'b0;
    set = 1'b0;
    readout = 1'b1;
    tick();
    tick();
    chk("freeze_out_index", 32'(out_index), 32'd0);
    chk("freeze_drain_ok", 32'(readout_ok), 32'd1);
    set = 1'b1;
    readout = 1'b0;
    fill_exp(8'h00);
    drain(1'b1);

    // Frame E: out-of-range coefficient, then reset in the middle of the drain
    beat(0, 3329, 1665, 1'b0);
    chk("range_err_set", 32'(range_err), 32'(RC_EXP));
    for (int k = 1; k < 128; k++) beat(k, 1665, 1665, k == 127);
    fill_exp(8'hFF);
    exp_b[0] = 8'hFE;
    for (int j = 0; j < 10; j++) begin
      chk("pre_abort_dout", 32'(comp_dout), 32'(exp_b[j]));
      readout = 1'b1;
      tick();
    end
    readout = 1'b0;
    chk("abort_index", 32'(out_index), 32'd10);
    chk("range_err_sticky", 32'(range_err), 32'(RC_EXP));
    reset = 1'b0;
    tick();
    chk("abort_dout", 32'(comp_dout), 32'd0);
    chk("abort_index0", 32'(out_index), 32'd0);
    chk("abort_readout_ok", 32'(readout_ok), 32'd0);
    chk("abort_readin_ok", 32'(readin_ok), 32'd0);
    chk("abort_range_err", 32'(range_err), 32'd0);
    reset = 1'b1;
    tick();
    chk("restart_readin_ok", 32'(readin_ok), 32'd1);

    // Frame F: pairs (0,1665) give alternating bits 0xAA
    for (int k = 0; k < 128; k++) beat(k, 0, 1665, k == 127);
    fill_exp(8'hAA);
    drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
